gate_counter: RTL and testbench



---
 rtl/gate_counter.sv | 169 ++++++++++++++++
 tb/tb_gate_counter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_counter.sv
// gate_counter
//   Counts rising edges of an asynchronous measured signal over a fixed window
//   of GATE_CYCLES system clocks. It publishes each completed window's count
//   with a one-cycle valid strobe, a saturation flag and the range flag that
//   was in effect while the window ran. Gates run back-to-back while enable
//   is high. A change of range during a gate discards that gate and restarts
//   it.
//
// Ports
//   clk            system clock; all logic runs on its rising edge
//   rst_n          asynchronous active-low reset
//   enable         1 = run continuous back-to-back gates
//   signalIn       asynchronous measured signal
//   highFrequency  asynchronous range flag
//   count          edges counted in the last completed gate
//   overflow       last completed gate saturated the edge counter
//   rangeHigh      range in effect for the last completed gate
//   countValid     one-cycle strobe marking a new result
//
// State | meaning
//   IDLE  | counters held at 0, waiting for enable
//   GATE  | window open: timer running, edges counted
//   DONE  | single cycle after a window closes; result just published
module gate_counter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   signalIn,
  input  logic                   highFrequency,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow,
  output logic                   rangeHigh,
  output logic                   countValid
);

  localparam int TW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic sig_meta, sig_sync, sig_prev;
  logic hf_meta, hf_sync;
  logic gate_range;
  logic [TW-1:0] timer;
  logic [COUNT_WIDTH-1:0] edge_cnt, edge_cnt_inc;
  logic sat, sat_inc;
  logic edge_pulse;
  logic start_gate, publish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_meta <= 1'b0;
      sig_sync <= 1'b0;
      sig_prev <= 1'b0;
      hf_meta  <= 1'b0;
      hf_sync  <= 1'b0;
    end else begin
      sig_meta <= signalIn;
      sig_sync <= sig_meta;
      sig_prev <= sig_sync;
      hf_meta  <= highFrequency;
      hf_sync  <= hf_meta;
    end
  end

  assign edge_pulse = sig_sync & ~sig_prev;

  // Value the edge counter takes this cycle if the gate stays open. The
  // result is loaded from this so an edge in the last gate cycle still counts.
  always_comb begin
    edge_cnt_inc = edge_cnt;
    sat_inc      = sat;
    if (edge_pulse) begin
      if (&edge_cnt) sat_inc = 1'b1;
      else           edge_cnt_inc = edge_cnt + COUNT_WIDTH'(1);
    end
  end

  // Timer runs down from GATE_CYCLES-1; terminal count 0 closes the gate.
  // Dropping enable takes priority over a range change, which takes priority
  // over the terminal count.
  always_comb begin
    state_nxt  = state;
    start_gate = 1'b0;
    publish    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt  = GATE;
          start_gate = 1'b1;
        end
      end
      GATE: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (hf_sync != gate_range) begin
          start_gate = 1'b1;
        end else if (timer == '0) begin
          state_nxt = DONE;
          publish   = 1'b1;
        end
      end
      DONE: begin
        if (enable) begin
          state_nxt  = GATE;
          start_gate = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer      <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      gate_range <= 1'b0;
    end else begin
      if (start_gate) gate_range <= hf_sync;
      if (start_gate) begin
        timer    <= TMR_LAST;
        edge_cnt <= '0;
        sat      <= 1'b0;
      end else if (state_nxt != GATE) begin
        timer    <= '0;
        edge_cnt <= '0;
        sat      <= 1'b0;
      end else begin
        timer    <= timer - TW'(1);
        edge_cnt <= edge_cnt_inc;
        sat      <= sat_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      overflow   <= 1'b0;
      rangeHigh  <= 1'b0;
      countValid <= 1'b0;
    end else begin
      countValid <= publish;
      if (publish) begin
        count     <= edge_cnt_inc;
        overflow  <= sat_inc;
        rangeHigh <= gate_range;
      end
    end
  end

endmodule

// File: tb/tb_gate_counter.sv
module tb_gate_counter;
  localparam int G    = 100;
  localparam int W8   = 8;
  localparam int W4   = 4;
  localparam int HMAX = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic signal_in = 1'b0;
  logic high_frequency = 1'b0;

  logic [W8-1:0] count8;
  logic          ov8, rh8, cv8;
  logic [W4-1:0] count4;
  logic          ov4, rh4, cv4;

  always #5 clk = ~clk;

  gate_counter #(.GATE_CYCLES(G), .COUNT_WIDTH(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .signalIn(signal_in),
    .highFrequency(high_frequency), .count(count8), .overflow(ov8),
    .rangeHigh(rh8), .countValid(cv8)
  );

  gate_counter #(.GATE_CYCLES(G), .COUNT_WIDTH(W4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .signalIn(signal_in),
    .highFrequency(high_frequency), .count(count4), .overflow(ov4),
    .rangeHigh(rh4), .countValid(cv4)
  );

  typedef struct packed {
    int   cyc;
    int   total;
    logic range;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit hist_sig[HMAX];
  bit hist_hf[HMAX];

  // Reference model: which cycle the current window opened in (-1 = none),
  // the range it was opened with, and whether the current cycle is the
  // publish cycle of a just-closed window.
  int m_start = -1;
  bit m_range = 1'b0;
  bit m_publishing = 1'b0;

  int held8 = 0, hov8 = 0, held4 = 0, hov4 = 0, hrange = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit sig_at(input int j);
    return (j < 0) ? 1'b0 : hist_sig[j];
  endfunction

  function automatic bit hf_at(input int j);
    return (j < 0) ? 1'b0 : hist_hf[j];
  endfunction

  // Each driven value reaches the edge detector two cycles later, so a
  // rise counted in cycle j is a 0->1 step between driven cycles j-3 and j-2.
  function automatic int window_edges(input int s);
    int n = 0;
    for (int j = s; j < s + G; j++)
      if (sig_at(j - 2) && !sig_at(j - 3)) n++;
    return n;
  endfunction

  function automatic int sat_val(input int t, input int w);
    int mx = (1 << w) - 1;
    return (t > mx) ? mx : t;
  endfunction

  // Decide what the circuit does in cycle k+1 given the inputs of cycle k.
  task automatic model_step(input int k, input bit en);
    bit hf_seen = hf_at(k - 2);
    if (m_publishing) begin
      m_publishing = 1'b0;
      if (en) begin m_start = k + 1; m_range = hf_seen; end
      else m_start = -1;
    end else if (m_start < 0) begin
      if (en) begin m_start = k + 1; m_range = hf_seen; end
    end else if (!en) begin
      m_start = -1;
    end else if (hf_seen != m_range) begin
      m_start = k + 1;
      m_range = hf_seen;
    end else if (k == m_start + G - 1) begin
      exp_q.push_back('{cyc: k + 1, total: window_edges(m_start), range: m_range});
      m_publishing = 1'b1;
      m_start = -1;
    end
  endtask

  task automatic step(input bit en, input bit s, input bit h);
    @(posedge clk);
    #1;
    cyc++;
    enable = en;
    signal_in = s;
    high_frequency = h;
    hist_sig[cyc] = s;
    hist_hf[cyc] = h;
    if (rst_n) model_step(cyc, en);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    signal_in = 1'b0;
    high_frequency = 1'b0;
    hist_sig[cyc] = 1'b0;
    hist_hf[cyc] = 1'b0;
    m_start = -1;
    m_publishing = 1'b0;
    exp_q.delete();
    #1;
    check("rst_count8", int'(count8), 0);
    check("rst_overflow8", int'(ov8), 0);
    check("rst_range8", int'(rh8), 0);
    check("rst_valid8", int'(cv8), 0);
    check("rst_count4", int'(count4), 0);
    check("rst_valid4", int'(cv4), 0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic monitor_cycle();
    bit strobe;
    exp_t e;
    if (!rst_n) begin
      held8 = 0; hov8 = 0; held4 = 0; hov4 = 0; hrange = 0;
    end
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_result: no countValid in cycle %0d, expected count %0d", e.cyc, e.total);
    end
    strobe = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    if (strobe) begin
      e = exp_q.pop_front();
      held8  = sat_val(e.total, W8);
      hov8   = (e.total > (1 << W8) - 1) ? 1 : 0;
      held4  = sat_val(e.total, W4);
      hov4   = (e.total > (1 << W4) - 1) ? 1 : 0;
      hrange = int'(e.range);
    end
    check("valid8", int'(cv8), int'(strobe));
    check("valid4", int'(cv4), int'(strobe));
    check("count8", int'(count8), held8);
    check("overflow8", int'(ov8), hov8);
    check("range8", int'(rh8), hrange);
    check("count4", int'(count4), held4);
    check("overflow4", int'(ov4), hov4);
    check("range4", int'(rh4), hrange);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      monitor_cycle();
    end
  end

  initial begin
    bit s;
    bit hf_r;
    int off;

    do_reset();

    // Toggle every clock, low range: 50 edges per gate, saturates 4-bit.
    s = 1'b0;
    for (int i = 0; i < 3 * (G + 1) + 5; i++) begin
      s = ~s;
      step(1'b1, s, 1'b0);
    end

    // Signal held low: empty gates, overflow clears.
    for (int i = 0; i < 2 * (G + 1); i++) step(1'b1, 1'b0, 1'b0);

    // High range from the start of the gate, signal period 4 clocks.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2 * (G + 1) + 3; i++) step(1'b1, (i % 4) < 2, 1'b1);

    // Range flips 40 cycles into a gate: that gate is aborted and restarts.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 2 * (G + 1); i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);

    // Enable dropped 50 cycles into a gate, then resumed.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    s = 1'b0;
    for (int i = 0; i < G + 1 + 50; i++) begin
      s = ~s;
      step(1'b1, s, 1'b0);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < G + 5; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);

    // Asynchronous reset between clock edges in the middle of a gate.
    #2;
    do_reset();
    s = 1'b0;
    for (int i = 0; i < G + 5; i++) begin
      s = ~s;
      step(1'b1, s, 1'b0);
    end

    // Randomized operation: random or toggling signal, occasional range
    // flips and enable drop-outs.
    off = 0;
    hf_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (off > 0) off--;
      else if ($urandom_range(0, 299) == 0) off = int'($urandom_range(1, 20));
      if ($urandom_range(0, 199) == 0) hf_r = ~hf_r;
      if (((i / 400) % 2) == 1) s = ~s;
      else s = 1'($urandom_range(0, 1));
      step(off == 0, s, hf_r);
    end

    for (int i = 0; i < G + 10; i++) step(1'b0, 1'b0, 1'b0);
    #3;
    check("pending_results", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
